// File: rtl/gf180mcu_osu_sc_tbus_pkg.sv
// -----------------------------------------------------------------------------
// gf180mcu_osu_sc_tbus_pkg
// Shared types and constants for the tristate-bus receive endpoint.
//   tbus_state_e    : tenure-tracking FSM state (2 bits)
//   ERRCNT_W        : width of the optional error counter
//                     (GF180MCU_OSU_SC_TBUS_RX_ERRCNT_EN)
//   errcnt_sat_add  : saturating add of a 0..2 increment onto the error count
// The FIFO entry struct {src, data} depends on module parameters, so it is
// declared with localparam widths inside the FIFO module.
// -----------------------------------------------------------------------------
package gf180mcu_osu_sc_tbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_HELD    = 2'd2,
    ST_CONTEND = 2'd3
  } tbus_state_e;

  localparam int ERRCNT_W = 8;

  function automatic logic [ERRCNT_W-1:0] errcnt_sat_add(
    input logic [ERRCNT_W-1:0] cnt,
    input logic [1:0]          inc
  );
    logic [ERRCNT_W:0] sum;
    sum = {1'b0, cnt} + {{(ERRCNT_W-1){1'b0}}, inc};
    return sum[ERRCNT_W] ? '1 : sum[ERRCNT_W-1:0];
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_tbus_rx_fifo2.sv
// -----------------------------------------------------------------------------
// gf180mcu_osu_sc_tbus_rx_fifo2
// Two-entry FIFO holding {src, data} words with a registered head.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push         : request to enqueue {i_src, i_data}
//   i_pop          : consumer ready; a pop happens only when non-empty
//   i_src, i_data  : word to enqueue
//   o_src, o_data  : registered head entry (zero after reset)
//   o_valid        : FIFO non-empty
//   o_drop         : push refused because full with no simultaneous pop
// -----------------------------------------------------------------------------
module gf180mcu_osu_sc_tbus_rx_fifo2
  import gf180mcu_osu_sc_tbus_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SRCW  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [SRCW-1:0]  i_src,
  input  logic [WIDTH-1:0] i_data,
  output logic [SRCW-1:0]  o_src,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop
);

  typedef struct packed {
    logic [SRCW-1:0]  src;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t     r_mem [2];
  entry_t     r_head;
  entry_t     w_din;
  entry_t     w_head_nxt;
  logic       r_wp;
  logic       r_rp;
  logic [1:0] r_cnt;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_rp_nxt;

  assign w_din   = '{src: i_src, data: i_data};
  assign w_empty = (r_cnt == 2'd0);
  assign w_full  = (r_cnt == 2'd2);
  assign w_pop   = i_pop && !w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && w_full && !w_pop;

  // The next head is either the word being written right now (when the read
  // pointer lands on the write slot) or an entry already in storage.
  assign w_rp_nxt   = w_pop ? ~r_rp : r_rp;
  assign w_head_nxt = (w_push && (w_rp_nxt == r_wp)) ? w_din : r_mem[w_rp_nxt];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_cnt  <= 2'd0;
      r_head <= '0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      r_rp   <= w_rp_nxt;
      r_cnt  <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      r_head <= w_head_nxt;
    end
  end

  // Storage carries no reset; occupancy is tracked by r_cnt alone.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= w_din;
  end

  assign o_src   = r_head.src;
  assign o_data  = r_head.data;
  assign o_valid = !w_empty;

endmodule

// File: rtl/gf180mcu_osu_sc_tbus_rx.sv
// -----------------------------------------------------------------------------
// gf180mcu_osu_sc_tbus_rx
// Receive endpoint of a multi-drop tristate bus built from tbuf cells. Watches
// the per-driver enables and the resolved bus; once a single driver's tenure
// has been stable for SETTLE cycles it captures one word with the driver
// index into a 2-entry FIFO. Flags contention and overflow (sticky).
// Optional: define GF180MCU_OSU_SC_TBUS_RX_ERRCNT_EN to add ERR_CNT, a
// saturating count of contention entries plus dropped captures.
// Ports:
//   CLK, RN     : clock, asynchronous active-low reset
//   BUS         : resolved bus value
//   EN          : per-driver enables, active-high
//   READY       : consumer accepts head word when VALID & READY
//   CLR         : synchronous clear of sticky flags (and ERR_CNT)
//   DATA, SRC   : head-of-FIFO word and its driver index
//   VALID       : FIFO non-empty
//   CONTENTION  : sticky, two or more enables seen high in one cycle
//   OVF         : sticky, a capture was dropped on a full FIFO
//   ERR_CNT     : (optional) 8-bit saturating error count
// -----------------------------------------------------------------------------
module gf180mcu_osu_sc_tbus_rx
  import gf180mcu_osu_sc_tbus_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NDRV   = 4,
  parameter  int SETTLE = 2,
  localparam int SRCW   = $clog2(NDRV)
) (
  input  logic                CLK,
  input  logic                RN,
  input  logic [WIDTH-1:0]    BUS,
  input  logic [NDRV-1:0]     EN,
  input  logic                READY,
  input  logic                CLR,
  output logic [WIDTH-1:0]    DATA,
  output logic [SRCW-1:0]     SRC,
  output logic                VALID,
  output logic                CONTENTION,
  output logic                OVF
`ifdef GF180MCU_OSU_SC_TBUS_RX_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] ERR_CNT
`endif
);

  localparam int              CNTW     = 4;
  localparam int              NW       = $clog2(NDRV + 1);
  localparam logic [CNTW-1:0] SETTLE_C = CNTW'(SETTLE);

  tbus_state_e     r_state;
  tbus_state_e     w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic [SRCW-1:0] r_idx;
  logic [SRCW-1:0] w_idx_nxt;
  logic [SRCW-1:0] w_idx;
  logic [NW-1:0]   w_n;
  logic            w_none;
  logic            w_one;
  logic            w_multi;
  logic            w_capture;
  logic            w_drop;
  logic            r_contention;
  logic            r_ovf;

  // Popcount of EN and index of the (last) set bit; w_idx is only meaningful
  // when exactly one enable is high.
  always_comb begin
    w_n   = '0;
    w_idx = '0;
    for (int i = 0; i < NDRV; i++) begin
      if (EN[i]) begin
        w_n   = w_n + NW'(1);
        w_idx = SRCW'(i);
      end
    end
  end

  assign w_none  = (w_n == '0);
  assign w_one   = (w_n == NW'(1));
  assign w_multi = !w_none && !w_one;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_multi) begin
          w_state_nxt = ST_CONTEND;
        end else if (w_one) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = CNTW'(1);
          w_idx_nxt   = w_idx;
        end
      end
      ST_SETTLE: begin
        if (w_multi) begin
          w_state_nxt = ST_CONTEND;
        end else if (w_none) begin
          w_state_nxt = ST_IDLE;
        end else if (w_idx != r_idx) begin
          // Hand-over to another driver restarts the settle window.
          w_idx_nxt = w_idx;
          w_cnt_nxt = CNTW'(1);
        end else if (r_cnt == SETTLE_C) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HELD;
        end else begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
      end
      ST_HELD: begin
        if (w_multi) begin
          w_state_nxt = ST_CONTEND;
        end else if (w_none) begin
          w_state_nxt = ST_IDLE;
        end else if (w_idx != r_idx) begin
          w_state_nxt = ST_SETTLE;
          w_idx_nxt   = w_idx;
          w_cnt_nxt   = CNTW'(1);
        end
      end
      ST_CONTEND: begin
        // A lone survivor of a contention is not trusted; wait for a clean bus.
        if (w_none) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_contention <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      // A new event in the clear cycle wins over CLR.
      r_contention <= w_multi | (r_contention & ~CLR);
      r_ovf        <= w_drop  | (r_ovf        & ~CLR);
    end
  end

  gf180mcu_osu_sc_tbus_rx_fifo2 #(
    .WIDTH (WIDTH),
    .SRCW  (SRCW)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RN),
    .i_push  (w_capture),
    .i_pop   (READY),
    .i_src   (r_idx),
    .i_data  (BUS),
    .o_src   (SRC),
    .o_data  (DATA),
    .o_valid (VALID),
    .o_drop  (w_drop)
  );

  assign CONTENTION = r_contention;
  assign OVF        = r_ovf;

`ifdef GF180MCU_OSU_SC_TBUS_RX_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;
  logic [1:0]          w_err_inc;
  logic                w_enter_contend;

  assign w_enter_contend = (w_state_nxt == ST_CONTEND) && (r_state != ST_CONTEND);
  assign w_err_inc       = {1'b0, w_enter_contend} + {1'b0, w_drop};

  // Events coinciding with CLR are still counted into the cleared value.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_err_cnt <= '0;
    end else if (CLR) begin
      r_err_cnt <= errcnt_sat_add('0, w_err_inc);
    end else begin
      r_err_cnt <= errcnt_sat_add(r_err_cnt, w_err_inc);
    end
  end

  assign ERR_CNT = r_err_cnt;
`endif

endmodule

// File: tb/tb_gf180mcu_osu_sc_tbus_rx.sv
// -----------------------------------------------------------------------------
// tb_gf180mcu_osu_sc_tbus_rx
// Directed scenarios followed by randomized bus traffic, checked every cycle
// against a tenure-level reference model (driver age, captured-once flag,
// contention mode, queue of pending words).
// -----------------------------------------------------------------------------
module tb_gf180mcu_osu_sc_tbus_rx;

  localparam int WIDTH  = 8;
  localparam int NDRV   = 4;
  localparam int SETTLE = 2;

  logic       CLK   = 1'b0;
  logic       RN    = 1'b1;
  logic [7:0] BUS   = '0;
  logic [3:0] EN    = '0;
  logic       READY = 1'b0;
  logic       CLR   = 1'b0;
  logic [7:0] DATA;
  logic [1:0] SRC;
  logic       VALID;
  logic       CONTENTION;
  logic       OVF;
`ifdef GF180MCU_OSU_SC_TBUS_RX_ERRCNT_EN
  logic [7:0] ERR_CNT;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [9:0] m_q[$];
  int         m_drv   = -1;
  int         m_age   = 0;
  bit         m_capd  = 0;
  bit         m_cmode = 0;
  bit         m_cont  = 0;
  bit         m_ovf   = 0;

  always #5 CLK = ~CLK;

  gf180mcu_osu_sc_tbus_rx #(
    .WIDTH  (WIDTH),
    .NDRV   (NDRV),
    .SETTLE (SETTLE)
  ) dut (
    .CLK        (CLK),
    .RN         (RN),
    .BUS        (BUS),
    .EN         (EN),
    .READY      (READY),
    .CLR        (CLR),
    .DATA       (DATA),
    .SRC        (SRC),
    .VALID      (VALID),
    .CONTENTION (CONTENTION),
    .OVF        (OVF)
`ifdef GF180MCU_OSU_SC_TBUS_RX_ERRCNT_EN
    ,
    .ERR_CNT    (ERR_CNT)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drv   = -1;
    m_age   = 0;
    m_capd  = 0;
    m_cmode = 0;
    m_cont  = 0;
    m_ovf   = 0;
  endtask

  // One clock edge of the reference model, using the values sampled there.
  task automatic model_step(input logic [3:0] en, input logic [7:0] bus,
                            input logic rdy, input logic clr);
    int  n;
    int  idx;
    bit  cap;
    bit  pop;
    bit  drop;
    bit  full;
    n    = $countones(en);
    idx  = -1;
    for (int i = 0; i < 4; i++) if (en[i]) idx = i;
    cap  = 0;
    drop = 0;
    pop  = (m_q.size() != 0) && rdy;
    full = (m_q.size() == 2);
    if (n > 1) begin
      m_cmode = 1;
      m_drv   = -1;
    end else if (m_cmode) begin
      if (n == 0) m_cmode = 0;
    end else if (n == 0) begin
      m_drv = -1;
    end else if (idx != m_drv) begin
      m_drv  = idx;
      m_age  = 1;
      m_capd = 0;
    end else if (!m_capd) begin
      if (m_age == SETTLE) begin
        cap    = 1;
        m_capd = 1;
      end else begin
        m_age++;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (cap) begin
      if (full && !pop) drop = 1;
      else m_q.push_back({2'(idx), bus});
    end
    m_cont = (n > 1) || (m_cont && !clr);
    m_ovf  = drop || (m_ovf && !clr);
  endtask

  task automatic check_model();
    logic [9:0] h;
    chk("valid", {31'd0, VALID}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      h = m_q[0];
      chk("data", {24'd0, DATA}, {24'd0, h[7:0]});
      chk("src", {30'd0, SRC}, {30'd0, h[9:8]});
    end
    chk("contention", {31'd0, CONTENTION}, {31'd0, m_cont});
    chk("ovf", {31'd0, OVF}, {31'd0, m_ovf});
  endtask

  task automatic cyc(input logic [3:0] en, input logic [7:0] bus,
                     input logic rdy, input logic clr);
    EN    = en;
    BUS   = bus;
    READY = rdy;
    CLR   = clr;
    @(posedge CLK);
    model_step(en, bus, rdy, clr);
    #1;
    check_model();
  endtask

  initial begin
    logic [3:0] ren;
    logic [7:0] rbus;
    int         len;
    int         sel;

    // Power-on reset
    #1 RN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", {31'd0, VALID}, 32'd0);
    chk("rst_data", {24'd0, DATA}, 32'd0);
    chk("rst_src", {30'd0, SRC}, 32'd0);
    chk("rst_cont", {31'd0, CONTENTION}, 32'd0);
    chk("rst_ovf", {31'd0, OVF}, 32'd0);
    @(negedge CLK);
    RN = 1'b1;
    model_reset();
    cyc(4'b0000, 8'h00, 1'b1, 1'b0);

    // Single tenure: driver 1, VALID after 3 edges, popped next cycle
    cyc(4'b0010, 8'hA5, 1'b1, 1'b0);
    cyc(4'b0010, 8'hA5, 1'b1, 1'b0);
    chk("t1_lat_early", {31'd0, VALID}, 32'd0);
    cyc(4'b0010, 8'hA5, 1'b1, 1'b0);
    chk("t1_valid", {31'd0, VALID}, 32'd1);
    chk("t1_data", {24'd0, DATA}, 32'hA5);
    chk("t1_src", {30'd0, SRC}, 32'd1);
    cyc(4'b0010, 8'hA5, 1'b1, 1'b0);
    chk("t1_one_word", {31'd0, VALID}, 32'd0);
    cyc(4'b0010, 8'hA5, 1'b1, 1'b0);
    cyc(4'b0010, 8'hA5, 1'b1, 1'b0);
    cyc(4'b0000, 8'h00, 1'b1, 1'b0);

    // Short glitch: no capture
    cyc(4'b0100, 8'h3C, 1'b1, 1'b0);
    repeat (4) cyc(4'b0000, 8'h00, 1'b1, 1'b0);
    chk("glitch_valid", {31'd0, VALID}, 32'd0);

    // Contention then lone survivor: no capture until bus is idle
    cyc(4'b0011, 8'h55, 1'b1, 1'b0);
    repeat (4) cyc(4'b0001, 8'h55, 1'b1, 1'b0);
    chk("cont_flag", {31'd0, CONTENTION}, 32'd1);
    chk("cont_nocap", {31'd0, VALID}, 32'd0);
    cyc(4'b0000, 8'h00, 1'b1, 1'b0);
    repeat (3) cyc(4'b0001, 8'h5A, 1'b1, 1'b0);
    chk("cont_after_data", {24'd0, DATA}, 32'h5A);
    cyc(4'b0000, 8'h00, 1'b1, 1'b1);
    chk("cont_clr", {31'd0, CONTENTION}, 32'd0);

    // Overflow: three tenures, READY low
    repeat (3) cyc(4'b0001, 8'h11, 1'b0, 1'b0);
    repeat (3) cyc(4'b0100, 8'h22, 1'b0, 1'b0);
    repeat (3) cyc(4'b1000, 8'h33, 1'b0, 1'b0);
    chk("ovf_flag", {31'd0, OVF}, 32'd1);
    chk("ovf_head", {24'd0, DATA}, 32'h11);
    chk("ovf_head_src", {30'd0, SRC}, 32'd0);
    cyc(4'b0000, 8'h00, 1'b1, 1'b0);
    chk("ovf_second", {24'd0, DATA}, 32'h22);
    chk("ovf_second_src", {30'd0, SRC}, 32'd2);
    cyc(4'b0000, 8'h00, 1'b1, 1'b0);
    chk("ovf_drained", {31'd0, VALID}, 32'd0);
    cyc(4'b0000, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", {31'd0, OVF}, 32'd0);

    // Capture into full FIFO with simultaneous pop
    repeat (3) cyc(4'b0001, 8'hAA, 1'b0, 1'b0);
    repeat (3) cyc(4'b0010, 8'hBB, 1'b0, 1'b0);
    repeat (2) cyc(4'b0100, 8'hCC, 1'b0, 1'b0);
    cyc(4'b0100, 8'hCC, 1'b1, 1'b0);
    chk("fullpop_noovf", {31'd0, OVF}, 32'd0);
    chk("fullpop_head", {24'd0, DATA}, 32'hBB);
    cyc(4'b0000, 8'h00, 1'b1, 1'b0);
    chk("fullpop_tail", {24'd0, DATA}, 32'hCC);
    chk("fullpop_tail_src", {30'd0, SRC}, 32'd2);
    cyc(4'b0000, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-settle with a loaded FIFO and set flag
    repeat (3) cyc(4'b0010, 8'h77, 1'b0, 1'b0);
    cyc(4'b0110, 8'h00, 1'b0, 1'b0);
    cyc(4'b0000, 8'h00, 1'b0, 1'b0);
    cyc(4'b1000, 8'h44, 1'b0, 1'b0);
    #2 RN = 1'b0;
    #1;
    chk("arst_valid", {31'd0, VALID}, 32'd0);
    chk("arst_data", {24'd0, DATA}, 32'd0);
    chk("arst_src", {30'd0, SRC}, 32'd0);
    chk("arst_cont", {31'd0, CONTENTION}, 32'd0);
    chk("arst_ovf", {31'd0, OVF}, 32'd0);
    model_reset();
    #2 RN = 1'b1;
    repeat (2) cyc(4'b1000, 8'h99, 1'b0, 1'b0);
    chk("arst_fresh_early", {31'd0, VALID}, 32'd0);
    cyc(4'b1000, 8'h99, 1'b0, 1'b0);
    chk("arst_fresh_valid", {31'd0, VALID}, 32'd1);
    chk("arst_fresh_src", {30'd0, SRC}, 32'd3);
    chk("arst_fresh_data", {24'd0, DATA}, 32'h99);
    repeat (2) cyc(4'b0000, 8'h00, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int k = 0; k < 150; k++) begin
      len = $urandom_range(1, 6);
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        ren = 4'b0001 << $urandom_range(0, 3);
      end else if (sel < 7) begin
        ren = 4'b0000;
      end else begin
        ren = 4'($urandom_range(0, 15));
        while ($countones(ren) < 2) ren = 4'($urandom_range(0, 15));
      end
      for (int j = 0; j < len; j++) begin
        rbus = 8'($urandom);
        cyc(ren, rbus, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
